fifo_sync_param: RTL and testbench

Parametrised single-clock synchronous FIFO, the successor to the fixed 8-bit FIFO DUT driven by the existing `fifo_intf` UVM environment. It generalises data width and depth and adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. The existing signal names are kept so the current agent, driver and monitor connect unchanged at default parameters.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 41 ++++
 rtl/fifo_sync_param.sv | 115 +++++++++++
 tb/tb_fifo_sync_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Pointer/count widths are derived from the depth through fifo_log2.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32'sd8;
  localparam int FIFO_DEPTH_DEF = 32'sd32;

  // Ceiling log2 usable in constant expressions (value 1 yields 0).
  function automatic int fifo_log2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and an
// enable-gated registered read port. Only the read register is reset.
module fifo_mem #(
  parameter int WIDTH = 32'sd8,
  parameter int DEPTH = 32'sd32,
  parameter int AW    = 32'sd5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: same-address write in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost flags and one-cycle overflow/underflow pulses; all outputs registered.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter  int AF_THRESH  = FIFO_DEPTH - 32'sd4,
  parameter  int AE_THRESH  = 32'sd4,
  localparam int AW         = fifo_log2(FIFO_DEPTH),
  localparam int PW         = AW + 32'sd1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PW-1:0]         count,
  output logic [PW-1:0]         wrptr,
  output logic [PW-1:0]         rdptr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_C   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if ((FIFO_DEPTH < 32'sd4) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0)) begin : g_chk_depth
    $error("fifo_sync_param: FIFO_DEPTH must be a power of two and at least 4");
  end
  if ((AF_THRESH < 32'sd1) || (AF_THRESH > FIFO_DEPTH)) begin : g_chk_af
    $error("fifo_sync_param: AF_THRESH must lie in 1..FIFO_DEPTH");
  end
  if ((AE_THRESH < 32'sd0) || (AE_THRESH > (FIFO_DEPTH - 32'sd1))) begin : g_chk_ae
    $error("fifo_sync_param: AE_THRESH must lie in 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0] wrptr_r, rdptr_r, count_r, count_nxt_s;
  logic          empty_r, full_r, ae_r, af_r, ovf_r, unf_r;
  logic          wr_acc_s, rd_acc_s;

  // Accept decisions and next occupancy; a full FIFO still takes a write
  // when a read drains a slot in the same cycle, an empty one never bypasses.
  always_comb begin
    wr_acc_s    = wr_en & (~full_r | rd_en);
    rd_acc_s    = rd_en & ~empty_r;
    count_nxt_s = count_r;
    if (wr_acc_s & ~rd_acc_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (~wr_acc_s & rd_acc_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, count, flags and error pulses; flags track the next count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrptr_r <= ZERO_C;
      rdptr_r <= ZERO_C;
      count_r <= ZERO_C;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ae_r    <= 1'b1;
      af_r    <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      wrptr_r <= wr_acc_s ? (wrptr_r + ONE_C) : wrptr_r;
      rdptr_r <= rd_acc_s ? (rdptr_r + ONE_C) : rdptr_r;
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == ZERO_C);
      full_r  <= (count_nxt_s == DEPTH_C);
      ae_r    <= (count_nxt_s <= AE_C);
      af_r    <= (count_nxt_s >= AF_C);
      ovf_r   <= wr_en & full_r & ~rd_en;
      unf_r   <= rd_en & empty_r;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstN  (rstN),
    .we    (wr_acc_s),
    .waddr (wrptr_r[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc_s),
    .raddr (rdptr_r[AW-1:0]),
    .rdata (data_out)
  );

  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = ae_r;
  assign almost_full  = af_r;
  assign count        = count_r;
  assign wrptr        = wrptr_r;
  assign rdptr        = rdptr_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: default instance plus a
// 16-bit x 8-entry instance, checked against a queue-based reference model.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic       wr_en_d, rd_en_d, empty_d, full_d, ae_d, af_d, ovf_d, unf_d;
  logic [7:0] din_d, dout_d;
  logic [5:0] count_d, wrptr_d, rdptr_d;

  logic        wr_en_s, rd_en_s, empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic [15:0] din_s, dout_s;
  logic [3:0]  count_s, wrptr_s, rdptr_s;

  fifo_sync_param dut (
    .clk(clk), .rstN(rstN), .wr_en(wr_en_d), .data_in(din_d), .rd_en(rd_en_d),
    .data_out(dout_d), .empty(empty_d), .full(full_d), .almost_empty(ae_d),
    .almost_full(af_d), .count(count_d), .wrptr(wrptr_d), .rdptr(rdptr_d),
    .overflow(ovf_d), .underflow(unf_d)
  );

  fifo_sync_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)
  ) dut_s (
    .clk(clk), .rstN(rstN), .wr_en(wr_en_s), .data_in(din_s), .rd_en(rd_en_s),
    .data_out(dout_s), .empty(empty_s), .full(full_s), .almost_empty(ae_s),
    .almost_full(af_s), .count(count_s), .wrptr(wrptr_s), .rdptr(rdptr_s),
    .overflow(ovf_s), .underflow(unf_s)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          sel;
  int          m_depth, m_af, m_ae, m_wp, m_rp;
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  bit          m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic use_cfg(input bit s);
    sel     = s;
    m_depth = s ? 8 : 32;
    m_af    = s ? 6 : 28;
    m_ae    = s ? 1 : 4;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wp   = 0;
    m_rp   = 0;
    m_dout = 16'h0000;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, sel ? 32'(count_s) : 32'(count_d), 32'(n));
    chk({tag, ".empty"}, sel ? 32'(empty_s) : 32'(empty_d), 32'(n == 0));
    chk({tag, ".full"},  sel ? 32'(full_s)  : 32'(full_d),  32'(n == m_depth));
    chk({tag, ".aempty"}, sel ? 32'(ae_s)   : 32'(ae_d),    32'(n <= m_ae));
    chk({tag, ".afull"}, sel ? 32'(af_s)    : 32'(af_d),    32'(n >= m_af));
    chk({tag, ".wrptr"}, sel ? 32'(wrptr_s) : 32'(wrptr_d), 32'(m_wp));
    chk({tag, ".rdptr"}, sel ? 32'(rdptr_s) : 32'(rdptr_d), 32'(m_rp));
    chk({tag, ".dout"},  sel ? 32'(dout_s)  : 32'(dout_d),  32'(m_dout));
    chk({tag, ".ovf"},   sel ? 32'(ovf_s)   : 32'(ovf_d),   32'(m_ovf));
    chk({tag, ".unf"},   sel ? 32'(unf_s)   : 32'(unf_d),   32'(m_unf));
  endtask

  // Drive one cycle on the selected instance, advance the model, then check.
  task automatic step(input string tag, input bit w, input logic [15:0] d, input bit r);
    bit          mfull, mempty, wacc, racc;
    logic [15:0] dv;
    @(negedge clk);
    dv     = sel ? d : {8'h00, d[7:0]};
    mfull  = (mq.size() == m_depth);
    mempty = (mq.size() == 0);
    wacc   = w && (!mfull || r);
    racc   = r && !mempty;
    m_ovf  = w && mfull && !r;
    m_unf  = r && mempty;
    if (racc) begin
      m_dout = mq.pop_front();
      m_rp   = (m_rp + 1) % (2 * m_depth);
    end
    if (wacc) begin
      mq.push_back(dv);
      m_wp = (m_wp + 1) % (2 * m_depth);
    end
    wr_en_d = sel ? 1'b0 : w;
    rd_en_d = sel ? 1'b0 : r;
    din_d   = dv[7:0];
    wr_en_s = sel ? w : 1'b0;
    rd_en_s = sel ? r : 1'b0;
    din_s   = dv;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rstN = 1'b0;
    wr_en_d = 1'b0; rd_en_d = 1'b0; din_d = 8'h00;
    wr_en_s = 1'b0; rd_en_s = 1'b0; din_s = 16'h0000;
    model_reset();
    #12;
    use_cfg(1'b1);
    check_outputs("rst_small");
    use_cfg(1'b0);
    check_outputs("rst");
    @(negedge clk);
    rstN = 1'b1;
    step("idle", 1'b0, 16'h0, 1'b0);

    for (int i = 1; i <= 32; i++) step("fill", 1'b1, 16'(i), 1'b0);
    step("ovf", 1'b1, 16'h0021, 1'b0);
    step("ovf_clr", 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 32; i++) step("drain", 1'b0, 16'h0, 1'b1);
    step("unf", 1'b0, 16'h0, 1'b1);
    step("empty_both", 1'b1, 16'h0055, 1'b1);
    step("rd_one", 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 32; i++) step("fill2", 1'b1, 16'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("full_both", 1'b1, 16'(8'hA0 + i), 1'b1);
    for (int i = 0; i < 32; i++) step("drain2", 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 17; i++) step("burst", 1'b1, 16'(8'hC0 + i), 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    wr_en_d = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    step("post_rst", 1'b0, 16'h0, 1'b0);
    step("post_rst_rd", 1'b0, 16'h0, 1'b1);

    use_cfg(1'b1);
    step("s_idle", 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) step("s_fill", 1'b1, 16'hA5A0 + 16'(i), 1'b0);
    step("s_ovf", 1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) step("s_both", 1'b1, 16'h5A50 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) step("s_drain", 1'b0, 16'h0, 1'b1);
    step("s_unf", 1'b0, 16'h0, 1'b1);
    step("s_end", 1'b0, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
